enigma_plugboard_stage: RTL and testbench

- Steckerbrett stage directly upstream of the rotor stage.
- Holds a programmable table of up to MAX_PAIRS symmetric letter swaps and maps each incoming character through it.
- Registers the result and presents it to the rotor stage's 5-bit character input under a valid/ready handshake.
- Emits a one-cycle step pulse per accepted character, which drives rotor advance.
- Letters are encoded 0..25 (A..Z).

---
 rtl/enigma_plugboard_stage_if.sv | 38 +++
 rtl/enigma_plugboard_stage.sv | 194 +++++++++++++++++++
 tb/tb_enigma_plugboard_stage.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_plugboard_stage_if.sv
// Bus bundle for the plugboard stage: configuration channel, character input
// channel and the mapped-character channel toward the rotor stage.
interface enigma_plugboard_stage_if #(
    parameter int CNT_W = 4
);
    // Configuration channel
    logic             cfg_clear;
    logic             cfg_valid;
    logic [4:0]       cfg_a;
    logic [4:0]       cfg_b;
    logic             cfg_ready;
    logic             cfg_err;
    logic [CNT_W-1:0] pair_count;
    logic             busy;

    // Character input channel
    logic             in_valid;
    logic [4:0]       in_char;
    logic             in_ready;

    // Mapped output toward the rotor stage
    logic             out_valid;
    logic [4:0]       out_char;
    logic             out_ready;
    logic             step;

    // Upstream controller / bench side
    modport master (
        output cfg_clear, cfg_valid, cfg_a, cfg_b, in_valid, in_char, out_ready,
        input  cfg_ready, cfg_err, pair_count, busy, in_ready, out_valid, out_char, step
    );

    // Plugboard stage side
    modport slave (
        input  cfg_clear, cfg_valid, cfg_a, cfg_b, in_valid, in_char, out_ready,
        output cfg_ready, cfg_err, pair_count, busy, in_ready, out_valid, out_char, step
    );
endinterface

// File: rtl/enigma_plugboard_stage.sv
// Steckerbrett stage: a table of symmetric letter swaps (always an involution)
// maps each incoming character; the result is registered toward the rotor stage
// together with a one-cycle step pulse. A small FSM installs pairs after a
// legality check and can restore the identity table one entry per cycle.
module enigma_plugboard_stage #(
    parameter int MAX_PAIRS = 10,
    parameter int CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    enigma_plugboard_stage_if.slave bus
);
    localparam int               NUM_LETTERS = 26;
    localparam logic [4:0]       LAST_LETTER = 5'd25;
    localparam logic [CNT_W-1:0] MAX_PAIRS_C = CNT_W'(MAX_PAIRS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       a_q, a_d;
    logic [4:0]       b_q, b_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;
    logic             cfg_err_q, cfg_err_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_char_q, out_char_d;
    logic             step_q, step_d;

    logic [5*NUM_LETTERS-1:0] map_flat;
    logic [4:0]               map_a;
    logic [4:0]               map_b;
    logic [4:0]               mapped_char;
    logic                     cfg_ready;
    logic                     in_ready;
    logic                     cfg_fire;
    logic                     in_fire;
    logic                     reject;
    logic                     write_en;
    logic                     clear_en;

    assign write_en = (state_q == ST_WRITE);
    assign clear_en = (state_q == ST_CLEAR);

    // One register per letter; WRITE stores the partner, CLEAR walks idx back to identity.
    generate
        for (genvar gi = 0; gi < NUM_LETTERS; gi++) begin : g_entry
            localparam logic [4:0] LETTER = 5'(gi);
            logic [4:0] entry_q;

            // Entry update: reset to itself, swap on WRITE, restore on its CLEAR slot.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= LETTER;
                end else if (write_en && (a_q == LETTER)) begin
                    entry_q <= b_q;
                end else if (write_en && (b_q == LETTER)) begin
                    entry_q <= a_q;
                end else if (clear_en && (idx_q == LETTER)) begin
                    entry_q <= LETTER;
                end
            end

            assign map_flat[gi*5 +: 5] = entry_q;
        end
    endgenerate

    // Table lookups as 26:1 muxes; codes 26..31 have no entry and fall through unchanged.
    always_comb begin
        map_a       = a_q;
        map_b       = b_q;
        mapped_char = bus.in_char;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (a_q == 5'(i)) begin
                map_a = map_flat[i*5 +: 5];
            end
            if (b_q == 5'(i)) begin
                map_b = map_flat[i*5 +: 5];
            end
            if (bus.in_char == 5'(i)) begin
                mapped_char = map_flat[i*5 +: 5];
            end
        end
    end

    // Handshakes: config only starts with an empty output register and wins over data.
    always_comb begin
        cfg_ready = (state_q == ST_IDLE) && !bus.cfg_clear && !out_valid_q;
        in_ready  = (state_q == ST_IDLE) && !bus.cfg_clear && !bus.cfg_valid &&
                    (!out_valid_q || bus.out_ready);
        cfg_fire  = bus.cfg_valid && cfg_ready;
        in_fire   = bus.in_valid && in_ready;
        // A pair is legal only between two distinct, currently unswapped letters with room left.
        reject    = (a_q > LAST_LETTER) || (b_q > LAST_LETTER) || (a_q == b_q) ||
                    (map_a != a_q) || (map_b != b_q) || (pair_count_q == MAX_PAIRS_C);
    end

    // Config FSM next state: IDLE -> CHECK -> (WRITE | IDLE), IDLE -> CLEAR x26 -> IDLE.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        idx_d        = idx_q;
        pair_count_d = pair_count_q;
        cfg_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_clear) begin
                    state_d      = ST_CLEAR;
                    pair_count_d = '0;
                    idx_d        = '0;
                end else if (cfg_fire) begin
                    a_d     = bus.cfg_a;
                    b_d     = bus.cfg_b;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (reject) begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                pair_count_d = pair_count_q + 1'b1;
                state_d      = ST_IDLE;
            end
            ST_CLEAR: begin
                if (idx_q == LAST_LETTER) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: load on accept, drop on consume, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        step_d      = in_fire;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_char_d  = mapped_char;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers for the FSM, counters and output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            pair_count_q <= '0;
            cfg_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_char_q   <= '0;
            step_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            pair_count_q <= pair_count_d;
            cfg_err_q    <= cfg_err_d;
            out_valid_q  <= out_valid_d;
            out_char_q   <= out_char_d;
            step_q       <= step_d;
        end
    end

    assign bus.cfg_ready  = cfg_ready;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.pair_count = pair_count_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_char   = out_char_q;
    assign bus.step       = step_q;
endmodule

// File: tb/tb_enigma_plugboard_stage.sv
// Bench for the plugboard stage: directed scenarios plus randomized traffic,
// checked against a letter-swap table model and an expected-output queue.
module tb_enigma_plugboard_stage;
    localparam int MAX_PAIRS = 10;
    localparam int CNT_W     = 4;
    localparam int TIMEOUT   = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enigma_plugboard_stage_if #(.CNT_W(CNT_W)) bus ();

    enigma_plugboard_stage #(
        .MAX_PAIRS(MAX_PAIRS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: plain swap table over all 32 codes plus installed-pair count.
    int model_map [32];
    int model_pairs;
    int exp_q [$];

    bit prev_acc;
    bit last_in_acc;
    bit last_cfg_acc;
    bit bp_random;
    int err_cnt;
    int busy_cnt;
    int step_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic void model_identity();
        for (int i = 0; i < 32; i++) model_map[i] = i;
        model_pairs = 0;
    endfunction

    function automatic bit model_install(input int a, input int b);
        if (a > 25 || b > 25 || a == b) return 1'b0;
        if (model_map[a] != a || model_map[b] != b) return 1'b0;
        if (model_pairs == MAX_PAIRS) return 1'b0;
        model_map[a] = b;
        model_map[b] = a;
        model_pairs++;
        return 1'b1;
    endfunction

    // Observes the cycle at the falling edge: what the next rising edge will do.
    task automatic monitor();
        int want;
        check_eq("step_pulse", bus.step, prev_acc);
        if (bus.step)    step_cnt++;
        if (bus.cfg_err) err_cnt++;
        if (bus.busy)    busy_cnt++;
        if (bus.out_valid && bus.out_ready) begin
            check_eq("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check_eq("out_char", bus.out_char, want);
                $display("[TB] char out %0d expected %0d", bus.out_char, want);
            end
        end
        last_in_acc  = bus.in_valid && bus.in_ready;
        last_cfg_acc = bus.cfg_valid && bus.cfg_ready;
        if (last_in_acc) exp_q.push_back(model_map[bus.in_char]);
        prev_acc = last_in_acc;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) monitor();
        @(posedge clk);
        #1;
        if (bp_random) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_char(input int c);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_char  = 5'(c);
        do begin
            tick();
            t++;
        end while (!last_in_acc && t < TIMEOUT);
        check_eq("in_handshake", last_in_acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < TIMEOUT) begin
            tick();
            t++;
        end
        tick();
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    task automatic verify_all();
        for (int c = 0; c < 32; c++) send_char(c);
        drain();
    endtask

    task automatic cfg_handshake(input int a, input int b);
        int t;
        t = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_a     = 5'(a);
        bus.cfg_b     = 5'(b);
        do begin
            tick();
            t++;
        end while (!last_cfg_acc && t < TIMEOUT);
        check_eq("cfg_handshake", last_cfg_acc, 1);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic install(input int a, input int b);
        bit ok;
        cfg_handshake(a, b);
        ok      = model_install(a, b);
        err_cnt = 0;
        repeat (4) tick();
        check_eq("cfg_err_pulses", err_cnt, ok ? 0 : 1);
        check_eq("pair_count", bus.pair_count, model_pairs);
        $display("[TB] install %0d-%0d accepted=%0d pairs=%0d", a, b, ok, model_pairs);
    endtask

    task automatic do_clear();
        bus.cfg_clear = 1'b1;
        tick();
        bus.cfg_clear = 1'b0;
        busy_cnt = 0;
        repeat (30) tick();
        model_identity();
        check_eq("clear_busy_cycles", busy_cnt, 26);
        check_eq("clear_pair_count", bus.pair_count, model_pairs);
        $display("[TB] clear busy=%0d pairs=%0d", busy_cnt, bus.pair_count);
    endtask

    task automatic apply_reset();
        bus.cfg_clear = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_identity();
        prev_acc = 1'b0;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_char", bus.out_char, 0);
        check_eq("rst_step", bus.step, 0);
        check_eq("rst_cfg_err", bus.cfg_err, 0);
        check_eq("rst_pair_count", bus.pair_count, 0);
        check_eq("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset applied");
    endtask

    initial begin
        int hold_char;
        int r;
        int n;

        bus.cfg_clear = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_a     = '0;
        bus.cfg_b     = '0;
        bus.in_valid  = 1'b0;
        bus.in_char   = '0;
        bus.out_ready = 1'b1;
        bp_random     = 1'b0;
        step_cnt      = 0;
        err_cnt       = 0;
        busy_cnt      = 0;

        apply_reset();

        // Identity stream at full throughput.
        step_cnt = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 26; c++) begin
            bus.in_char = 5'(c);
            tick();
            check_eq("stream_accept", last_in_acc, 1);
            check_eq("stream_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        repeat (2) tick();
        check_eq("stream_steps", step_cnt, 26);
        drain();

        // Two pairs then the letters they touch plus an unswapped one.
        install(0, 4);
        install(7, 19);
        send_char(0);
        send_char(4);
        send_char(7);
        send_char(19);
        send_char(1);
        drain();
        check_eq("two_pairs_count", bus.pair_count, 2);

        // Backpressure: output held, nothing accepted, no step.
        send_char(0);
        hold_char = model_map[0];
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_char   = 5'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("bp_in_ready", bus.in_ready, 0);
            check_eq("bp_out_valid", bus.out_valid, 1);
            check_eq("bp_out_char", bus.out_char, hold_char);
            check_eq("bp_step", bus.step, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", bus.in_ready, 1);
        tick();
        check_eq("bp_release_accept", last_in_acc, 1);
        bus.in_valid = 1'b0;
        drain();

        // Rejections, then fill to the limit and try one more.
        install(3, 3);
        install(4, 9);
        install(27, 2);
        install(1, 2);
        install(3, 5);
        install(6, 8);
        install(10, 11);
        install(12, 13);
        install(14, 15);
        install(16, 17);
        install(18, 20);
        install(21, 22);
        check_eq("full_pair_count", bus.pair_count, MAX_PAIRS);
        verify_all();

        // Clear after three pairs.
        apply_reset();
        install(2, 11);
        install(5, 24);
        install(13, 25);
        verify_all();
        do_clear();
        verify_all();

        // Reset in the middle of CLEAR (idx = 10).
        install(12, 20);
        install(15, 23);
        bus.cfg_clear = 1'b1;
        tick();
        bus.cfg_clear = 1'b0;
        repeat (10) tick();
        check_eq("midclear_busy", bus.busy, 1);
        apply_reset();
        verify_all();

        // Reset while the pair is being checked.
        cfg_handshake(2, 9);
        check_eq("midcheck_busy", bus.busy, 1);
        apply_reset();
        repeat (4) tick();
        check_eq("midcheck_pairs", bus.pair_count, 0);
        verify_all();

        // Randomized traffic under random backpressure.
        bp_random = 1'b1;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                install($urandom_range(0, 27), $urandom_range(0, 27));
            end else if (r == 4) begin
                do_clear();
            end else begin
                n = $urandom_range(1, 8);
                for (int k = 0; k < n; k++) send_char($urandom_range(0, 31));
            end
        end
        drain();
        bp_random     = 1'b0;
        bus.out_ready = 1'b1;
        verify_all();
        check_eq("final_pair_count", bus.pair_count, model_pairs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
